aesl_deadlock_trace_unit: RTL and testbench

//  Synthesizable, parametrised deadlock detector and cycle tracer for dataflow regions of PROC_NUM processes.

---
 rtl/aesl_deadlock_trace_unit.sv | 256 +++++++++++++++++++++++++
 tb/tb_aesl_deadlock_trace_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aesl_deadlock_trace_unit.sv
// ---------------------------------------------------------------------------
// aesl_deadlock_trace_unit
//
// Deadlock detector and cycle tracer for a dataflow region of PROC_NUM
// processes. The unit watches the per-process blocked flags and declares
// deadlock once they have been nonzero and unchanged for STABLE_CYCLES
// cycles. At that point it snapshots the blocked flags and the wait-for
// matrix. It then walks every dependence cycle in the snapshot and streams
// one trace entry per visited process over a valid/ready port.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   dl_in_vec      bit i = process i is blocked
//   dep_mat        bit i*PROC_NUM+j = process i waits on process j
//   dl_detect_out  deadlock declared (sticky until reset)
//   trace_valid    trace entry valid
//   trace_ready    consumer accepts the entry
//   trace_cycle_id 1-based id of the cycle being walked
//   trace_proc_id  process id of this entry
//   trace_last     final entry of this walk
//   trace_err      walk did not close back on its origin (valid with last)
//   token_clear    one-cycle pulse after a walk completes
//   cycle_count    number of closed cycles reported (saturating)
//   report_done    every snapshot process has been reported
// ---------------------------------------------------------------------------
module aesl_deadlock_trace_unit #(
  parameter int PROC_NUM      = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8,
  localparam int ID_W         = $clog2(PROC_NUM)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PROC_NUM-1:0]          dl_in_vec,
  input  logic [PROC_NUM*PROC_NUM-1:0] dep_mat,
  output logic                         dl_detect_out,
  output logic                         trace_valid,
  input  logic                         trace_ready,
  output logic [CNT_W-1:0]             trace_cycle_id,
  output logic [ID_W-1:0]              trace_proc_id,
  output logic                         trace_last,
  output logic                         trace_err,
  output logic                         token_clear,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         report_done
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [PROC_NUM-1:0] ONE_VEC = PROC_NUM'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SELECT,
    ST_WALK,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [PROC_NUM-1:0]          prev_reg;
  logic [SC_W-1:0]              stab_cnt_reg;
  logic [PROC_NUM-1:0]          snap_reg;
  logic [PROC_NUM*PROC_NUM-1:0] snap_dep_reg;
  logic [PROC_NUM-1:0]          done_reg;
  logic [PROC_NUM-1:0]          visited_reg;
  logic [ID_W-1:0]              cur_reg;
  logic [ID_W-1:0]              origin_reg;
  logic [CNT_W-1:0]             cycle_count_reg;
  logic                         dl_detect_reg;
  logic                         token_clear_reg;

  // FSM strobes
  logic snap_load;
  logic walk_start;

  // Origin selection: lowest snapshot process not yet reported.
  logic [PROC_NUM-1:0] sel_cand;
  logic                sel_found;
  logic [ID_W-1:0]     sel_idx;

  // Successor of the current process inside the snapshot.
  logic [PROC_NUM-1:0] dep_rows [PROC_NUM];
  logic [PROC_NUM-1:0] succ_cand;
  logic                succ_found;
  logic [ID_W-1:0]     succ_idx;
  logic                succ_is_origin;
  logic                walk_last;
  logic                walk_err;
  logic                arm_ok;

  // Split the flat wait-for matrix into rows so the current row can be
  // picked with a narrow index.
  generate
    for (genvar gi = 0; gi < PROC_NUM; gi++) begin : g_rows
      assign dep_rows[gi] = snap_dep_reg[gi*PROC_NUM +: PROC_NUM];
    end
  endgenerate

  assign sel_cand  = snap_reg & ~done_reg;
  assign succ_cand = dep_rows[cur_reg] & snap_reg;

  // Two lowest-index priority encoders; the descending loop lets the
  // lowest set bit win.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    succ_found = 1'b0;
    succ_idx   = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (sel_cand[i]) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(i);
      end
      if (succ_cand[i]) begin
        succ_found = 1'b1;
        succ_idx   = ID_W'(i);
      end
    end
  end

  // A successor already reported by an earlier walk also ends this walk.
  // Without that, a tail leading into an already-traced loop would re-emit
  // processes that were reported before.
  assign succ_is_origin = succ_found && (succ_idx == origin_reg);
  assign walk_last      = !succ_found || succ_is_origin ||
                          visited_reg[succ_idx] || done_reg[succ_idx];
  assign walk_err       = walk_last && !succ_is_origin;
  assign arm_ok         = (dl_in_vec != '0) && (dl_in_vec == prev_reg);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    snap_load      = 1'b0;
    walk_start     = 1'b0;
    trace_valid    = 1'b0;
    trace_cycle_id = '0;
    trace_proc_id  = '0;
    trace_last     = 1'b0;
    trace_err      = 1'b0;
    report_done    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (dl_in_vec != '0) begin
          if (STABLE_CYCLES == 1) begin
            snap_load  = 1'b1;
            state_next = ST_SELECT;
          end else begin
            state_next = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (!arm_ok) begin
          state_next = ST_IDLE;
        end else if (stab_cnt_reg == SC_W'(STABLE_CYCLES - 1)) begin
          snap_load  = 1'b1;
          state_next = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (!sel_found) begin
          state_next = ST_DONE;
        end else begin
          walk_start = 1'b1;
          state_next = ST_WALK;
        end
      end
      ST_WALK: begin
        trace_valid    = 1'b1;
        trace_cycle_id = cycle_count_reg + 1'b1;
        trace_proc_id  = cur_reg;
        trace_last     = walk_last;
        trace_err      = walk_err;
        if (trace_ready && walk_last) begin
          state_next = ST_SELECT;
        end
      end
      ST_DONE: begin
        report_done = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_reg        <= '0;
      stab_cnt_reg    <= '0;
      snap_reg        <= '0;
      snap_dep_reg    <= '0;
      done_reg        <= '0;
      visited_reg     <= '0;
      cur_reg         <= '0;
      origin_reg      <= '0;
      cycle_count_reg <= '0;
      dl_detect_reg   <= 1'b0;
      token_clear_reg <= 1'b0;
    end else begin
      token_clear_reg <= 1'b0;

      if (state_reg == ST_IDLE && dl_in_vec != '0) begin
        prev_reg     <= dl_in_vec;
        stab_cnt_reg <= SC_W'(1);
      end
      if (state_reg == ST_ARM) begin
        if (!arm_ok) begin
          stab_cnt_reg <= '0;
        end else begin
          stab_cnt_reg <= stab_cnt_reg + 1'b1;
        end
      end

      // Snapshot is taken once; later input changes no longer matter.
      if (snap_load) begin
        snap_reg      <= dl_in_vec;
        snap_dep_reg  <= dep_mat;
        dl_detect_reg <= 1'b1;
      end

      if (walk_start) begin
        cur_reg     <= sel_idx;
        origin_reg  <= sel_idx;
        visited_reg <= ONE_VEC << sel_idx;
      end

      if (state_reg == ST_WALK && trace_ready) begin
        if (!walk_last) begin
          cur_reg     <= succ_idx;
          visited_reg <= visited_reg | (ONE_VEC << succ_idx);
        end else begin
          done_reg        <= done_reg | visited_reg;
          token_clear_reg <= 1'b1;
          if (!walk_err && cycle_count_reg != '1) begin
            cycle_count_reg <= cycle_count_reg + 1'b1;
          end
        end
      end
    end
  end

  assign dl_detect_out = dl_detect_reg;
  assign token_clear   = token_clear_reg;
  assign cycle_count   = cycle_count_reg;

endmodule

// File: tb/tb_aesl_deadlock_trace_unit.sv
// ---------------------------------------------------------------------------
// Testbench for aesl_deadlock_trace_unit (PROC_NUM=8, STABLE_CYCLES=16,
// CNT_W=8). The stimulus process pushes hand-computed trace entries into a
// queue; a monitor process compares every presented entry with the queue
// head and pops it on a transfer.
// ---------------------------------------------------------------------------
module tb_aesl_deadlock_trace_unit;

  typedef struct packed {
    logic [7:0] cid;
    logic [2:0] pid;
    logic       last;
    logic       err;
  } entry_t;

  logic        clock;
  logic        reset;
  logic [7:0]  dl_in_vec;
  logic [63:0] dep_mat;
  logic        dl_detect_out;
  logic        trace_valid;
  logic        trace_ready;
  logic [7:0]  trace_cycle_id;
  logic [2:0]  trace_proc_id;
  logic        trace_last;
  logic        trace_err;
  logic        token_clear;
  logic [7:0]  cycle_count;
  logic        report_done;

  int     checks;
  int     errors;
  int     tok_cnt;
  int     tok_base;
  entry_t exp_q[$];

  aesl_deadlock_trace_unit #(
    .PROC_NUM(8),
    .STABLE_CYCLES(16),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dl_in_vec(dl_in_vec),
    .dep_mat(dep_mat),
    .dl_detect_out(dl_detect_out),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_cycle_id(trace_cycle_id),
    .trace_proc_id(trace_proc_id),
    .trace_last(trace_last),
    .trace_err(trace_err),
    .token_clear(token_clear),
    .cycle_count(cycle_count),
    .report_done(report_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h required 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, got);
    end
  endtask

  function automatic entry_t mk(input int cid, input int pid, input bit last, input bit err);
    entry_t e;
    e.cid  = 8'(cid);
    e.pid  = 3'(pid);
    e.last = last;
    e.err  = err;
    return e;
  endfunction

  task automatic set_dep(input int i, input int j);
    dep_mat[i*8 + j] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs_zero(input string name);
    check(name, 32'({dl_detect_out, trace_valid, trace_cycle_id, trace_proc_id,
                     trace_last, trace_err, token_clear, cycle_count, report_done}), 32'd0);
  endtask

  task automatic do_reset();
    dl_in_vec   = '0;
    dep_mat     = '0;
    trace_ready = 1'b1;
    reset       = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    check_outs_zero("reset_outputs");
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!report_done && n < 400) begin
      tick();
      n++;
    end
    check(name, 32'(report_done), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!trace_valid && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(trace_valid), 32'd1);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the
  // active edge.
  initial begin
    entry_t got;
    tok_cnt = 0;
    forever begin
      @(negedge clock);
      if (trace_valid) begin
        got = {trace_cycle_id, trace_proc_id, trace_last, trace_err};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry got cid=%0d pid=%0d last=%0b err=%0b required none",
                   got.cid, got.pid, got.last, got.err);
        end else begin
          check($sformatf("entry cid=%0d pid=%0d", exp_q[0].cid, exp_q[0].pid),
                32'(got), 32'(exp_q[0]));
          if (trace_ready) void'(exp_q.pop_front());
        end
      end
      if (token_clear) tok_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    dl_in_vec   = '0;
    dep_mat     = '0;
    trace_ready = 1'b1;

    // ---- reset state
    do_reset();

    // ---- glitch filter: 10 cycles, 15 cycles (one short), value change
    dl_in_vec = 8'h03;
    repeat (10) tick();
    dl_in_vec = 8'h00;
    repeat (20) tick();
    check("glitch10_detect", 32'(dl_detect_out), 32'd0);

    dl_in_vec = 8'h03;
    repeat (15) tick();
    dl_in_vec = 8'h00;
    repeat (20) tick();
    check("glitch15_detect", 32'(dl_detect_out), 32'd0);

    dl_in_vec = 8'h03;
    repeat (10) tick();
    dl_in_vec = 8'h07;
    repeat (10) tick();
    dl_in_vec = 8'h00;
    repeat (20) tick();
    check("glitch_change_detect", 32'(dl_detect_out), 32'd0);
    check("glitch_report_done", 32'(report_done), 32'd0);

    // ---- two-process mutual wait, held exactly 16 cycles
    tok_base = tok_cnt;
    set_dep(0, 1);
    set_dep(1, 0);
    exp_q.push_back(mk(1, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 1, 0));
    dl_in_vec = 8'h03;
    repeat (16) tick();
    dl_in_vec = 8'h00;
    check("mutual_detect_at_16", 32'(dl_detect_out), 32'd1);
    wait_done("mutual_done");
    check("mutual_count", 32'(cycle_count), 32'd1);
    check("mutual_token_clear", 32'(tok_cnt - tok_base), 32'd1);
    check("mutual_entries_left", 32'(exp_q.size()), 32'd0);
    check("mutual_valid_in_done", 32'(trace_valid), 32'd0);

    // ---- two disjoint cycles with backpressure on the 2nd entry
    do_reset();
    tok_base = tok_cnt;
    set_dep(0, 1);
    set_dep(1, 0);
    set_dep(2, 3);
    set_dep(3, 2);
    exp_q.push_back(mk(1, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 1, 0));
    exp_q.push_back(mk(2, 2, 0, 0));
    exp_q.push_back(mk(2, 3, 1, 0));
    trace_ready = 1'b0;
    dl_in_vec   = 8'h0F;
    wait_valid("disjoint_first_valid");
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid_held", 32'(trace_valid), 32'd1);
      check("bp_proc_id_held", 32'(trace_proc_id), 32'd1);
      check("bp_cycle_id_held", 32'(trace_cycle_id), 32'd1);
    end
    trace_ready = 1'b1;
    wait_done("disjoint_done");
    check("disjoint_count", 32'(cycle_count), 32'd2);
    check("disjoint_token_clear", 32'(tok_cnt - tok_base), 32'd2);
    check("disjoint_entries_left", 32'(exp_q.size()), 32'd0);

    // ---- self-loop, dead end, tail into an already reported loop
    do_reset();
    tok_base = tok_cnt;
    set_dep(4, 4);
    set_dep(6, 4);
    exp_q.push_back(mk(1, 4, 1, 0));
    exp_q.push_back(mk(2, 5, 1, 1));
    exp_q.push_back(mk(2, 6, 1, 1));
    dl_in_vec = 8'h70;
    wait_done("mixed_done");
    check("mixed_count", 32'(cycle_count), 32'd1);
    check("mixed_token_clear", 32'(tok_cnt - tok_base), 32'd3);
    check("mixed_entries_left", 32'(exp_q.size()), 32'd0);

    // ---- reset asserted during the 2nd entry
    do_reset();
    set_dep(0, 1);
    set_dep(1, 0);
    exp_q.push_back(mk(1, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 1, 0));
    trace_ready = 1'b0;
    dl_in_vec   = 8'h03;
    wait_valid("midwalk_first_valid");
    trace_ready = 1'b1;
    tick();
    check("midwalk_second_pid", 32'(trace_proc_id), 32'd1);
    trace_ready = 1'b0;
    reset       = 1'b0;
    #1;
    check_outs_zero("midwalk_reset_outputs");
    exp_q.delete();
    tick();
    tok_base = tok_cnt;
    exp_q.push_back(mk(1, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 1, 0));
    trace_ready = 1'b1;
    reset       = 1'b1;
    wait_done("redetect_done");
    check("redetect_detect", 32'(dl_detect_out), 32'd1);
    check("redetect_count", 32'(cycle_count), 32'd1);
    check("redetect_token_clear", 32'(tok_cnt - tok_base), 32'd1);
    check("redetect_entries_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
